// File: rtl/imem_load_ctrl.sv
// Program loader for imem: streams host words into consecutive word addresses
// from a base, bounds-checked against imem depth, and releases core fetch when done.
module imem_load_ctrl #(
  parameter int ADDRSIZE = 1024,
  parameter int BITWIDTH = 32,
  parameter int CNTW     = $clog2(ADDRSIZE + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] base_addr,
  input  logic [CNTW-1:0]     num_words,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] write_addr,
  output logic [BITWIDTH-1:0] write_data,
  output logic                write_valid,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                core_run
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;
  localparam int IDXW = BITWIDTH - 2;
  localparam int SUMW = CNTW + BITWIDTH;

  logic [0:0]          state_q, state_d;
  logic [CNTW-1:0]     remaining_q, remaining_d;
  logic [IDXW-1:0]     wr_idx_q, wr_idx_d;
  logic [BITWIDTH-1:0] write_addr_q, write_addr_d;
  logic [BITWIDTH-1:0] write_data_q, write_data_d;
  logic                write_valid_q, write_valid_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                core_run_q, core_run_d;

  logic [IDXW-1:0] base_idx;
  logic [SUMW-1:0] range_end;
  logic            range_err;
  logic            beat;
  logic            unused_addr_bits;

  // Byte-offset bits of the base are don't-care; loads are word aligned.
  assign base_idx         = base_addr[BITWIDTH-1:2];
  assign unused_addr_bits = ^base_addr[1:0];

  // Widened sum so a huge base cannot wrap back into range.
  assign range_end = SUMW'(base_idx) + SUMW'(num_words);
  assign range_err = range_end > SUMW'(ADDRSIZE);

  // Handshake: a word transfers on a cycle where in_valid and in_ready are
  // both high; in_ready is high for the whole of LOAD regardless of in_valid.
  assign in_ready = (state_q == LOAD);
  assign beat     = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    wr_idx_d      = wr_idx_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    write_valid_d = 1'b0;
    done_d        = 1'b0;
    error_d       = error_q;
    core_run_d    = core_run_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          core_run_d = 1'b0;
          if (range_err) begin
            error_d = 1'b1;
          end else if (num_words == '0) begin
            done_d     = 1'b1;
            core_run_d = 1'b1;
          end else begin
            state_d     = LOAD;
            remaining_d = num_words;
            wr_idx_d    = base_idx;
          end
        end
      end
      LOAD: begin
        // Abort wins over a beat in the same cycle; that beat is discarded.
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          write_valid_d = 1'b1;
          write_data_d  = in_data;
          write_addr_d  = {wr_idx_q, 2'b00};
          wr_idx_d      = wr_idx_q + IDXW'(1);
          remaining_d   = remaining_q - CNTW'(1);
          if (remaining_q == CNTW'(1)) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            core_run_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      wr_idx_q      <= '0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      write_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      core_run_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      wr_idx_q      <= wr_idx_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      write_valid_q <= write_valid_d;
      done_q        <= done_d;
      error_q       <= error_d;
      core_run_q    <= core_run_d;
    end
  end

  assign write_addr  = write_addr_q;
  assign write_data  = write_data_q;
  assign write_valid = write_valid_q;
  assign busy        = (state_q == LOAD);
  assign done        = done_q;
  assign error       = error_q;
  assign core_run    = core_run_q;

endmodule
